// File: rtl/pdm_pkt_tx_if.sv
// Ingress bus between the packet transmitter and pdm_core.
// master = transmitter (drives the byte bus), slave = pdm_core (returns ack).
interface pdm_pkt_tx_if;
  logic       bnd_plse;
  logic [7:0] data_in;
  logic       ack;

  modport master (output bnd_plse, output data_in, input ack);
  modport slave  (input bnd_plse, input data_in, output ack);
endinterface

// File: rtl/pdm_pkt_tx.sv
// Packet transmitter: host byte FIFO plus TX FSM that serialises whole packets onto pdm_core ingress.
// Optional ack timeout abort enabled by defining PDM_PKT_TX_ACK_TIMEOUT_EN.
module pdm_pkt_tx #(
  parameter int DEPTH       = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         wr_last,
  output logic         wr_full,
  output logic         err_ovf,
  pdm_pkt_tx_if.master ing,
  output logic         busy,
  output logic         pkt_sent,
  output logic         err_timeout
);
  // state    | meaning
  // S_IDLE   | waiting for a fully buffered packet
  // S_HDR    | popping header, bnd_plse registered high
  // S_PAY    | popping payload bytes until the one tagged last
  // S_WAIT   | packet on the bus, waiting for ack (or timeout)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_cfg_err
    $error("pdm_pkt_tx: unsupported DEPTH or ACK_TIMEOUT");
  end

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [AW:0]   pkt_cnt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [8:0]    rd_entry;
  logic          wr_acc;
  logic          pop;
  logic          pkt_in;
  logic          pkt_out;
  logic          expire;

  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  assign wr_acc   = wr_en && (count != FULL_CNT);
  assign pop      = (state == S_HDR) || (state == S_PAY);
  assign rd_entry = mem[rd_ptr];
  assign pkt_in   = wr_acc && wr_last;
  assign pkt_out  = pop && rd_entry[8];

  always_comb begin
    count_nxt = count;
    case ({wr_acc, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
      wr_full <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      wr_full <= (count_nxt == FULL_CNT);
      if (wr_en && !wr_acc) err_ovf <= 1'b1;
      if (pkt_in && !pkt_out)
        pkt_cnt <= pkt_cnt + CNT_ONE;
      else if (!pkt_in && pkt_out)
        pkt_cnt <= pkt_cnt - CNT_ONE;
    end
  end

  // Only complete packets are ever started, so HDR/PAY never pop an empty FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (pkt_cnt != '0) state_nxt = S_HDR;
      S_HDR, S_PAY: state_nxt = rd_entry[8] ? S_WAIT : S_PAY;
      S_WAIT:       if (ing.ack || expire) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      pkt_sent     <= 1'b0;
      ing.bnd_plse <= 1'b0;
      ing.data_in  <= 8'h00;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      pkt_sent     <= (state == S_WAIT) && ing.ack;
      ing.bnd_plse <= (state == S_HDR);
      ing.data_in  <= pop ? rd_entry[7:0] : 8'h00;
    end
  end

`ifdef PDM_PKT_TX_ACK_TIMEOUT_EN
  localparam int TW = (ACK_TIMEOUT > 255) ? 16 : 8;
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = 1;

  logic [TW-1:0] timer;

  // ack has priority over a timer reaching terminal count in the same cycle.
  assign expire = (state == S_WAIT) && !ing.ack && (timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= expire;
      if (state != S_WAIT && state_nxt == S_WAIT)
        timer <= TMR_LOAD;
      else if (state == S_WAIT && timer != '0)
        timer <= timer - TMR_ONE;
    end
  end
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
